// File: rtl/cpu_pkg.sv
// Shared encodings for the control pipeline: control-word layout, ALU/PC selects,
// per-stage control subsets and the X-scrubbing helper for decoder outputs.
package cpu_pkg;

    localparam int CTRL_W = 10;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam int B_REGDST   = 9;
    localparam int B_BRANCH   = 8;
    localparam int B_MEMREAD  = 7;
    localparam int B_MEMTOREG = 6;
    localparam int B_ALUOP_HI = 5;
    localparam int B_ALUOP_LO = 4;
    localparam int B_MEMWRITE = 3;
    localparam int B_ALUSRC   = 2;
    localparam int B_REGWRITE = 1;
    localparam int B_JUMP     = 0;

    typedef enum logic [5:0] {
        OP_R   = 6'h00,
        OP_J   = 6'h02,
        OP_BEQ = 6'h04,
        OP_LW  = 6'h23,
        OP_SW  = 6'h2b
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10
    } pc_sel_e;

    localparam ctrl_t BUBBLE = '0;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    // An unknown control bit falls to the else path in simulation, so X reads as 0.
    function automatic ctrl_t scrub_ctrl(input ctrl_t raw);
        ctrl_t clean;
        clean = BUBBLE;
        for (int i = 0; i < CTRL_W; i++) begin
            if (raw[i]) begin
                clean[i] = 1'b1;
            end
        end
        return clean;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use / branch / jump arbitration for the ID-EX boundary.
// Priority is taken branch, then load-use stall, then jump in ID.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_branch,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_jump,
    input  logic             ex_zero,
    output logic             stall,
    output logic             flush_ifid,
    output logic [1:0]       pc_redirect
);

    logic br_taken;
    logic load_use;

    assign br_taken = ex_branch & ex_zero;
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        stall       = 1'b0;
        flush_ifid  = 1'b0;
        pc_redirect = PC_SEQ;
        if (br_taken) begin
            flush_ifid  = 1'b1;
            pc_redirect = PC_BRANCH;
        end else if (load_use) begin
            stall = 1'b1;
        end else if (id_jump) begin
            flush_ifid  = 1'b1;
            pc_redirect = PC_JUMP;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard squashing and
// saturating stall/flush event counters.
module ctrl_pipe
    import cpu_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       id_ctrl,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic [1:0]       ex_aluOp,
    output logic             ex_aluSrc,
    output logic [REG_W-1:0] ex_dst,
    output logic             mem_memRead,
    output logic             mem_memWrite,
    output logic             wb_regWrite,
    output logic             wb_MemtoReg,
    output logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             flush_ifid,
    output logic [1:0]       pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            id_clean;
    ex_ctrl_t         ex_in;
    logic [REG_W-1:0] ex_rt_in;
    logic [REG_W-1:0] ex_dst_in;

    ex_ctrl_t         ex_q;
    logic [REG_W-1:0] ex_rt_q;
    logic [REG_W-1:0] ex_dst_q;
    mem_ctrl_t        mem_q;
    logic [REG_W-1:0] mem_dst_q;
    wb_ctrl_t         wb_q;
    logic [REG_W-1:0] wb_dst_q;

    logic             id_jump;

    assign id_clean = scrub_ctrl(id_ctrl);

    // Jump is masked during reset so flush_ifid/pc_redirect read 0 while rst_n is low.
    assign id_jump = id_clean[B_JUMP] & rst_n;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .ex_branch   (ex_q.branch),
        .ex_mem_read (ex_q.mem_read),
        .ex_rt       (ex_rt_q),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_jump     (id_jump),
        .ex_zero     (ex_zero),
        .stall       (stall),
        .flush_ifid  (flush_ifid),
        .pc_redirect (pc_redirect)
    );

    // Stall, taken branch and an ID jump all send a bubble into EX.
    always_comb begin
        ex_in     = '0;
        ex_rt_in  = '0;
        ex_dst_in = '0;
        if (!(stall || flush_ifid)) begin
            ex_in.branch     = id_clean[B_BRANCH];
            ex_in.mem_read   = id_clean[B_MEMREAD];
            ex_in.mem_to_reg = id_clean[B_MEMTOREG];
            ex_in.alu_op     = id_clean[B_ALUOP_HI:B_ALUOP_LO];
            ex_in.mem_write  = id_clean[B_MEMWRITE];
            ex_in.alu_src    = id_clean[B_ALUSRC];
            ex_in.reg_write  = id_clean[B_REGWRITE];
            ex_rt_in         = id_rt;
            ex_dst_in        = id_clean[B_REGDST] ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_rt_q   <= '0;
            ex_dst_q  <= '0;
            mem_q     <= '0;
            mem_dst_q <= '0;
            wb_q      <= '0;
            wb_dst_q  <= '0;
        end else begin
            ex_q             <= ex_in;
            ex_rt_q          <= ex_rt_in;
            ex_dst_q         <= ex_dst_in;
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_dst_q        <= ex_dst_q;
            wb_q.mem_to_reg  <= mem_q.mem_to_reg;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_dst_q         <= mem_dst_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_ifid && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign ex_aluOp     = ex_q.alu_op;
    assign ex_aluSrc    = ex_q.alu_src;
    assign ex_dst       = ex_dst_q;
    assign mem_memRead  = mem_q.mem_read;
    assign mem_memWrite = mem_q.mem_write;
    assign wb_regWrite  = wb_q.reg_write;
    assign wb_MemtoReg  = wb_q.mem_to_reg;
    assign wb_dst       = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and randomized bench for ctrl_pipe against an instruction-level model;
// a second instance with 2-bit counters exercises saturation.
module tb_ctrl_pipe;

    localparam int REG_W = 5;

    localparam bit [9:0] C_NOP = 10'b0000000000;
    localparam bit [9:0] C_R   = 10'b1000100010;
    localparam bit [9:0] C_LW  = 10'b0011000110;
    localparam bit [9:0] C_SW  = 10'b0000001100;
    localparam bit [9:0] C_BEQ = 10'b0100010000;
    localparam bit [9:0] C_J   = 10'b0000000001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [9:0]       id_ctrl = '0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic [REG_W-1:0] id_rd = '0;
    logic             ex_zero = 1'b0;

    logic [1:0]       ex_aluOp, s_ex_aluOp;
    logic             ex_aluSrc, s_ex_aluSrc;
    logic [REG_W-1:0] ex_dst, s_ex_dst;
    logic             mem_memRead, s_mem_memRead;
    logic             mem_memWrite, s_mem_memWrite;
    logic             wb_regWrite, s_wb_regWrite;
    logic             wb_MemtoReg, s_wb_MemtoReg;
    logic [REG_W-1:0] wb_dst, s_wb_dst;
    logic             stall, s_stall;
    logic             flush_ifid, s_flush_ifid;
    logic [1:0]       pc_redirect, s_pc_redirect;
    logic [15:0]      stall_cnt, flush_cnt;
    logic [1:0]       s_stall_cnt, s_flush_cnt;

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_zero(ex_zero), .ex_aluOp(ex_aluOp), .ex_aluSrc(ex_aluSrc),
        .ex_dst(ex_dst), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .wb_regWrite(wb_regWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
        .stall(stall), .flush_ifid(flush_ifid), .pc_redirect(pc_redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_zero(ex_zero), .ex_aluOp(s_ex_aluOp), .ex_aluSrc(s_ex_aluSrc),
        .ex_dst(s_ex_dst), .mem_memRead(s_mem_memRead), .mem_memWrite(s_mem_memWrite),
        .wb_regWrite(s_wb_regWrite), .wb_MemtoReg(s_wb_MemtoReg), .wb_dst(s_wb_dst),
        .stall(s_stall), .flush_ifid(s_flush_ifid), .pc_redirect(s_pc_redirect),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: one record per in-flight instruction; index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       valid;
        bit [9:0] ctrl;
        bit [4:0] rt;
        bit [4:0] dst;
    } instr_t;

    instr_t      stages[3];
    int unsigned stalls;
    int unsigned flushes;
    int          vectors;
    int          miscompares;
    bit          e_stall;
    bit          e_flush;
    bit [1:0]    e_redirect;

    function automatic int unsigned sat(input int unsigned n, input int unsigned max);
        return (n > max) ? max : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) stages[i] = '{1'b0, 10'd0, 5'd0, 5'd0};
        stalls  = 0;
        flushes = 0;
    endtask

    task automatic predict();
        bit br;
        bit lu;
        bit jp;
        br = stages[0].valid && stages[0].ctrl[8] && (ex_zero === 1'b1);
        lu = stages[0].valid && stages[0].ctrl[7] && (stages[0].rt != 0) &&
             ((stages[0].rt == id_rs) || (stages[0].rt == id_rt));
        jp = (id_ctrl[0] === 1'b1);
        e_stall    = rst_n && !br && lu;
        e_flush    = rst_n && (br || (!lu && jp));
        e_redirect = !rst_n ? 2'd0 : br ? 2'd2 : (!lu && jp) ? 2'd1 : 2'd0;
    endtask

    task automatic compare_all();
        instr_t ex;
        instr_t mem;
        instr_t wb;
        ex  = stages[0];
        mem = stages[1];
        wb  = stages[2];
        check("ex_aluOp",     ex_aluOp,     ex.valid ? ex.ctrl[5:4] : 2'd0);
        check("ex_aluSrc",    ex_aluSrc,    ex.valid && ex.ctrl[2]);
        if (!rst_n || ex.valid) check("ex_dst", ex_dst, ex.dst);
        check("mem_memRead",  mem_memRead,  mem.valid && mem.ctrl[7]);
        check("mem_memWrite", mem_memWrite, mem.valid && mem.ctrl[3]);
        check("wb_regWrite",  wb_regWrite,  wb.valid && wb.ctrl[1]);
        check("wb_MemtoReg",  wb_MemtoReg,  wb.valid && wb.ctrl[6]);
        if (!rst_n || wb.valid) check("wb_dst", wb_dst, wb.dst);
        check("stall",        stall,        e_stall);
        check("flush_ifid",   flush_ifid,   e_flush);
        check("pc_redirect",  pc_redirect,  e_redirect);
        check("stall_cnt",    stall_cnt,    sat(stalls, 65535));
        check("flush_cnt",    flush_cnt,    sat(flushes, 65535));
        check("sat_stall_cnt", s_stall_cnt, sat(stalls, 3));
        check("sat_flush_cnt", s_flush_cnt, sat(flushes, 3));
    endtask

    task automatic drive(input bit [9:0] c, input bit [4:0] rs, input bit [4:0] rt,
                         input bit [4:0] rd, input bit z);
        id_ctrl = c;
        id_rs   = rs;
        id_rt   = rt;
        id_rd   = rd;
        ex_zero = z;
        #1;
        predict();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            stages[2] = stages[1];
            stages[1] = stages[0];
            if (e_stall || e_flush || id_ctrl[0])
                stages[0] = '{1'b0, 10'd0, 5'd0, 5'd0};
            else
                stages[0] = '{1'b1, id_ctrl, id_rt, id_ctrl[9] ? id_rd : id_rt};
            if (e_stall) stalls++;
            if (e_flush) flushes++;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        clear_model();
        predict();
        compare_all();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit [9:0]    c;
        bit [4:0]    rs, rt, rd;
        bit          z;
        int unsigned r;
        vectors     = 0;
        miscompares = 0;
        clear_model();

        // Reset held with a jump presented in ID: everything must read 0.
        drive(C_J, 1, 2, 3, 1);
        check("reset_flush", flush_ifid, 1'b0);
        tick();
        rst_n = 1'b1;

        // First R-type after reset: aluOp at +1, writeback at +3.
        drive(C_R, 1, 2, 5, 0); tick();
        drive(C_NOP, 0, 0, 0, 0);
        check("r_ex_aluOp", ex_aluOp, 2'b10);
        tick();
        drive(C_NOP, 0, 0, 0, 0); tick();
        drive(C_NOP, 0, 0, 0, 0);
        check("r_wb_regWrite", wb_regWrite, 1'b1);
        check("r_wb_dst", wb_dst, 5'd5);
        tick();

        // Load-use: one stall cycle, bubble, then the dependent add.
        drive(C_LW, 1, 8, 0, 0); tick();
        drive(C_R, 8, 3, 9, 0);
        check("lu_stall", stall, 1'b1);
        tick();
        drive(C_R, 8, 3, 9, 0);
        check("lu_stall_once", stall, 1'b0);
        check("lu_bubble_aluOp", ex_aluOp, 2'b00);
        check("lu_lw_in_mem", mem_memRead, 1'b1);
        tick();
        drive(C_NOP, 0, 0, 0, 0);
        check("lu_add_aluOp", ex_aluOp, 2'b10);
        check("lu_add_dst", ex_dst, 5'd9);
        check("lu_stall_cnt", stall_cnt, 16'd1);
        tick();

        // No false stalls.
        drive(C_LW, 1, 0, 0, 0); tick();
        drive(C_R, 0, 0, 4, 0);
        check("nfs_r0", stall, 1'b0);
        tick();
        drive(C_LW, 1, 8, 0, 0); tick();
        drive(C_SW, 1, 2, 0, 0);
        check("nfs_sw", stall, 1'b0);
        tick();

        // Taken and not-taken branch.
        drive(C_BEQ, 1, 2, 0, 0); tick();
        drive(C_R, 3, 4, 6, 1);
        check("br_redirect", pc_redirect, 2'b10);
        check("br_flush", flush_ifid, 1'b1);
        tick();
        drive(C_NOP, 0, 0, 0, 0);
        check("br_bubble_aluOp", ex_aluOp, 2'b00);
        check("br_flush_cnt", flush_cnt, 16'd1);
        tick();
        drive(C_BEQ, 1, 2, 0, 0); tick();
        drive(C_R, 3, 4, 6, 0);
        check("bnt_flush", flush_ifid, 1'b0);
        check("bnt_redirect", pc_redirect, 2'b00);
        tick();

        // Branch taken while ID also matches a load in EX: flush wins.
        drive(10'b0110010000, 1, 8, 0, 0); tick();
        drive(C_R, 8, 3, 7, 1);
        check("sim_stall", stall, 1'b0);
        check("sim_redirect", pc_redirect, 2'b10);
        tick();
        drive(C_NOP, 0, 0, 0, 0);
        check("sim_stall_cnt", stall_cnt, 16'd1);
        check("sim_flush_cnt", flush_cnt, 16'd2);
        tick();

        // Jump in ID, and its slot writes nothing.
        drive(C_J, 0, 0, 0, 0);
        check("j_redirect", pc_redirect, 2'b01);
        check("j_flush", flush_ifid, 1'b1);
        tick();
        drive(C_NOP, 0, 0, 0, 0); tick();
        drive(C_NOP, 0, 0, 0, 0); tick();
        drive(C_NOP, 0, 0, 0, 0);
        check("j_wb_regWrite", wb_regWrite, 1'b0);
        check("j_flush_cnt", flush_cnt, 16'd3);
        tick();

        // Mid-stream reset, then four stalls to saturate the 2-bit counter.
        drive(C_R, 1, 2, 3, 0); tick();
        drive(C_LW, 1, 4, 0, 0); tick();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(C_LW, 1, 8, 0, 0); tick();
            drive(C_R, 8, 8, 9, 0); tick();
            drive(C_R, 8, 8, 9, 0); tick();
        end
        drive(C_NOP, 0, 0, 0, 0);
        check("sat_hold", s_stall_cnt, 2'd3);
        check("sat_main", stall_cnt, 16'd4);
        tick();

        // Random instruction stream; ID is held across stalls and zeroed after flushes.
        c = C_NOP; rs = 0; rt = 0; rd = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) apply_reset();
            if (!e_stall) begin
                r = $urandom_range(0, 6);
                case (r)
                    0: c = C_R;
                    1: c = C_LW;
                    2: c = C_SW;
                    3: c = C_BEQ;
                    4: c = C_J;
                    5: begin r = $urandom(); c = r[9:0]; end
                    default: c = C_LW;
                endcase
                if (e_flush) c = C_NOP;
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 31));
            end
            z = ($urandom_range(0, 1) == 1);
            drive(c, rs, rt, rd, z);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
